// File: rtl/dff_pipe_pkg.sv
// dff_pipe shared constants and helpers.
// Optional build macro: DFF_PIPE_TAPS_EN (exposes per-stage taps).
package dff_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int cnt_w(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// dff_stage: one WIDTH-bit register with valid bit.
// clr wins over en; en=0 holds.
module dff_stage #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q       <= RST_VAL;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: stallable DEPTH-stage delay line with occupancy count.
// Optional build macro: DFF_PIPE_TAPS_EN adds the taps port.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          d,
  input  logic                      d_valid,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [cnt_w(DEPTH)-1:0]   count
`ifdef DFF_PIPE_TAPS_EN
  ,
  output logic [DEPTH*WIDTH-1:0]    taps
`endif
);

  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] data [DEPTH];
  logic             vld  [DEPTH];
  logic             clr;

  assign clr = rst | flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] sd;
    logic             sv;

    if (i == 0) begin : g_head
      assign sd = d;
      assign sv = d_valid;
    end else begin : g_body
      assign sd = data[i-1];
      assign sv = vld[i-1];
    end

    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .clr     (clr),
      .en      (en),
      .d       (sd),
      .d_valid (sv),
      .q       (data[i]),
      .q_valid (vld[i])
    );

`ifdef DFF_PIPE_TAPS_EN
    assign taps[i*WIDTH +: WIDTH] = data[i];
`endif
  end

  assign q       = data[DEPTH-1];
  assign q_valid = vld[DEPTH-1];

  // Word in and word out on the same edge cancel, so count tracks popcount(vld).
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(d_valid) - CW'(vld[DEPTH-1]);
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed and random checks of dff_pipe
// against a queue-based delay-line model.
module tb_dff_pipe;

  localparam int W = 8;
  localparam int D = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, en, flush, d_valid;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          q_valid;
  logic [CW-1:0] count;
`ifdef DFF_PIPE_TAPS_EN
  logic [D*W-1:0] taps;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mdata [$];
  bit           mvld  [$];

  always #5 clk = ~clk;

  dff_pipe #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .flush   (flush),
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid),
    .count   (count)
`ifdef DFF_PIPE_TAPS_EN
    ,
    .taps    (taps)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mdata.delete();
    mvld.delete();
    for (int i = 0; i < D; i++) begin
      mdata.push_back(8'h00);
      mvld.push_back(1'b0);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    foreach (mvld[i]) n += int'(mvld[i]);
    return n;
  endfunction

  task automatic step(input logic r, input logic f, input logic e,
                      input logic [W-1:0] dd, input logic dv);
    rst = r; flush = f; en = e; d = dd; d_valid = dv;
    @(posedge clk);
    if (r || f) begin
      model_clear();
    end else if (e) begin
      mdata.push_front(dd);
      mvld.push_front(dv);
      void'(mdata.pop_back());
      void'(mvld.pop_back());
    end
    #1;
    chk("q", 64'(q), 64'(mdata[D-1]));
    chk("q_valid", 64'(q_valid), 64'(mvld[D-1]));
    chk("count", 64'(count), 64'(model_count()));
`ifdef DFF_PIPE_TAPS_EN
    begin
      logic [D*W-1:0] et;
      for (int i = 0; i < D; i++) et[i*W +: W] = mdata[i];
      chk("taps", 64'(taps), 64'(et));
    end
`endif
  endtask

  initial begin
    logic r, f, e;
    model_clear();
    rst = 1'b1; flush = 1'b0; en = 1'b1; d = 8'hFF; d_valid = 1'b1;

    // reset with busy inputs
    step(1, 0, 1, 8'hFF, 1);
    step(1, 0, 1, 8'hFF, 1);
    chk("rst_q", 64'(q), 64'h00);
    chk("rst_qv", 64'(q_valid), 64'h0);
    chk("rst_cnt", 64'(count), 64'h0);
    step(0, 0, 0, 8'hFF, 1);
    chk("rel_cnt", 64'(count), 64'h0);

    // stream
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, W'(i), 1);
      if (i == 4) chk("stream_q4", 64'({q_valid, q}), 64'h101);
      if (i == 5) chk("stream_q5", 64'({q_valid, q}), 64'h102);
    end
    step(0, 0, 1, 8'h06, 1);
    chk("stream_q6", 64'(q), 64'h03);

    // stall
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 8'hA1, 1);
    step(0, 0, 1, 8'hA2, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, W'(i * 8'h5A), 1);
    chk("stall_cnt", 64'(count), 64'h2);
    step(0, 0, 1, 8'h00, 0);
    step(0, 0, 1, 8'h00, 0);
    chk("stall_q", 64'({q_valid, q}), 64'h1A1);

    // bubble
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 8'h10, 1);
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h12, 1);
    chk("bub_cnt", 64'(count), 64'h2);
    step(0, 0, 1, 8'h00, 0);
    chk("bub_o1", 64'({q_valid, q}), 64'h110);
    step(0, 0, 1, 8'h00, 0);
    chk("bub_o2", 64'({q_valid, q}), 64'h011);
    step(0, 0, 1, 8'h00, 0);
    chk("bub_o3", 64'({q_valid, q}), 64'h112);

    // flush beats en
    for (int i = 0; i < 4; i++) step(0, 0, 1, W'(8'hC0 + i), 1);
    chk("full_cnt", 64'(count), 64'h4);
    step(0, 1, 1, 8'h55, 1);
    chk("fl_state", 64'({count, q_valid, q}), 64'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 8'h00, 0);
      tests++;
      assert (q !== 8'h55) else begin
        fails++;
        $error("FAIL fl_leak: observed %0h expected not 55", q);
      end
    end

`ifdef DFF_PIPE_TAPS_EN
    step(0, 1, 0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, W'(i), 1);
    chk("taps_const", 64'(taps), 64'h01020304);
`endif

    // random
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 29) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, f, e, W'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
